memctrl_host: RTL and testbench

Synchronous bus initiator that drives the MEMCTRL SRAM-style port (ADDR/CSB/WEB/OEB/CE/IDATA, read data on ODATA) from a simple valid/ready command interface. It sits between the BIST engine or system logic and MEMCTRL, and produces the setup, strobe and recovery phasing in clock cycles. Reads return through a response strobe. Writes take data through a per-beat handshake.

---
 rtl/memctrl_host.sv | 207 ++++++++++++++++++++
 tb/tb_memctrl_host.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl_host.sv
// SRAM-style bus initiator for MEMCTRL: turns valid/ready commands into setup/strobe/recovery phasing.
// Optional MEMIF_BURST_EN: honour CMD_LEN as a multi-beat burst with auto-incrementing address.
module memctrl_host #(
    parameter logic [3:0] SETUP_CYC  = 4'd1,
    parameter logic [3:0] STROBE_CYC = 4'd1,
    parameter logic [3:0] RECOV_CYC  = 4'd1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic [15:0] CMD_ADDR,
    input  logic [7:0]  CMD_LEN,
    input  logic        WD_VALID,
    input  logic [7:0]  WD_DATA,
    output logic        WD_READY,
    output logic        RD_VALID,
    output logic [7:0]  RD_DATA,
    output logic        BUSY,
    output logic [15:0] ADDR,
    output logic        CE,
    output logic        CSB,
    output logic        WEB,
    output logic        OEB,
    output logic [7:0]  IDATA,
    input  logic [7:0]  ODATA
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAITD  = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        RECOV  = 3'd4
    } state_t;

    // A programmed count of zero still yields one cycle in that phase.
    localparam logic [3:0] SETUP_N  = (SETUP_CYC  == 4'd0) ? 4'd1 : SETUP_CYC;
    localparam logic [3:0] STROBE_N = (STROBE_CYC == 4'd0) ? 4'd1 : STROBE_CYC;
    localparam logic [3:0] RECOV_N  = (RECOV_CYC  == 4'd0) ? 4'd1 : RECOV_CYC;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        ce_q, ce_d;
    logic        csb_q, csb_d;
    logic        web_q, web_d;
    logic        oeb_q, oeb_d;
    logic [7:0]  idata_q, idata_d;
    logic        phase_last;
    logic        more_beats;
    logic        bus_active;

`ifdef MEMIF_BURST_EN
    logic [7:0]  beats_q, beats_d;
    assign more_beats = (beats_q != 8'd0);
`else
    logic        unused_len;
    assign unused_len = ^CMD_LEN;
    assign more_beats = 1'b0;
`endif

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            SETUP:   phase_last = (phase_q == SETUP_N - 4'd1);
            STROBE:  phase_last = (phase_q == STROBE_N - 4'd1);
            RECOV:   phase_last = (phase_q == RECOV_N - 4'd1);
            default: phase_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef MEMIF_BURST_EN
        beats_d    = beats_q;
`endif
        case (state_q)
            IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    addr_d  = CMD_ADDR;
                    wr_d    = CMD_WR;
                    phase_d = 4'd0;
`ifdef MEMIF_BURST_EN
                    beats_d = CMD_LEN;
`endif
                    state_d = CMD_WR ? WAITD : SETUP;
                end
            end
            WAITD: begin
                if (WD_VALID) begin
                    wdata_d = WD_DATA;
                    phase_d = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                phase_d = phase_q + 4'd1;
                if (phase_last) begin
                    phase_d = 4'd0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                phase_d = phase_q + 4'd1;
                if (phase_last) begin
                    phase_d = 4'd0;
                    state_d = RECOV;
                    if (!wr_q) begin
                        rd_data_d  = ODATA;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            RECOV: begin
                phase_d = phase_q + 4'd1;
                if (phase_last) begin
                    phase_d = 4'd0;
                    if (more_beats) begin
                        addr_d  = addr_q + 16'd1;
`ifdef MEMIF_BURST_EN
                        beats_d = beats_q - 8'd1;
`endif
                        state_d = wr_q ? WAITD : SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus pins are registered from the next state so they change exactly with the FSM.
    always_comb begin
        bus_active  = (state_d == SETUP) || (state_d == STROBE);
        ce_d        = (state_d == STROBE);
        csb_d       = !bus_active;
        web_d       = !(bus_active && wr_d);
        oeb_d       = !(bus_active && !wr_d);
        idata_d     = (bus_active && wr_d) ? wdata_d : 8'h00;
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            phase_q     <= 4'd0;
            addr_q      <= 16'h0000;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            idata_q     <= 8'h00;
`ifdef MEMIF_BURST_EN
            beats_q     <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            cmd_ready_q <= cmd_ready_d;
            ce_q        <= ce_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            idata_q     <= idata_d;
`ifdef MEMIF_BURST_EN
            beats_q     <= beats_d;
`endif
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign WD_READY  = (state_q == WAITD);
    assign BUSY      = (state_q != IDLE);
    assign RD_VALID  = rd_valid_q;
    assign RD_DATA   = rd_data_q;
    assign ADDR      = addr_q;
    assign CE        = ce_q;
    assign CSB       = csb_q;
    assign WEB       = web_q;
    assign OEB       = oeb_q;
    assign IDATA     = idata_q;

endmodule

// File: tb/tb_memctrl_host.sv
// Directed bench for memctrl_host: default-timing instance plus a stretched-timing instance.
module tb_memctrl_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_valid2, cmd_wr;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid;
    logic [7:0]  wd_data;

    logic        cmd_ready, wd_ready, rd_valid, busy, ce, csb, web, oeb;
    logic [7:0]  rd_data, idata, odata;
    logic [15:0] addr;

    logic        cmd_ready2, wd_ready2, rd_valid2, busy2, ce2, csb2, web2, oeb2;
    logic [7:0]  rd_data2, idata2, odata2;
    logic [15:0] addr2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory model: returns low address byte XOR 0xB5 while output-enabled (0x0010 -> 0xA5).
    assign odata  = !oeb  ? (addr[7:0]  ^ 8'hB5) : 8'h00;
    assign odata2 = !oeb2 ? (addr2[7:0] ^ 8'hB5) : 8'h00;

    memctrl_host u_dut (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WR(cmd_wr),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .WD_VALID(wd_valid), .WD_DATA(wd_data),
        .WD_READY(wd_ready), .RD_VALID(rd_valid), .RD_DATA(rd_data), .BUSY(busy), .ADDR(addr),
        .CE(ce), .CSB(csb), .WEB(web), .OEB(oeb), .IDATA(idata), .ODATA(odata)
    );

    memctrl_host #(.SETUP_CYC(4'd2), .STROBE_CYC(4'd3), .RECOV_CYC(4'd2)) u_dut2 (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid2), .CMD_READY(cmd_ready2), .CMD_WR(cmd_wr),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .WD_VALID(wd_valid), .WD_DATA(wd_data),
        .WD_READY(wd_ready2), .RD_VALID(rd_valid2), .RD_DATA(rd_data2), .BUSY(busy2), .ADDR(addr2),
        .CE(ce2), .CSB(csb2), .WEB(web2), .OEB(oeb2), .IDATA(idata2), .ODATA(odata2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_wr = 1'b0;
        cmd_addr = 16'h0000; cmd_len = 8'd0; wd_valid = 1'b0; wd_data = 8'h00;
        tick; tick;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_csb", csb, 1);
        chk("rst_ce", ce, 0);
        chk("rst_web_oeb", {web, oeb}, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_rd", {rd_valid, rd_data}, 9'h000);
        chk("rst_wd_ready", wd_ready, 0);
        rst = 1'b0;
        tick;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single write, data pre-asserted; a read command presented while busy must be ignored.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0010; wd_valid = 1'b1; wd_data = 8'hA5;
        tick;
        cmd_wr = 1'b0; cmd_addr = 16'h0077;
        chk("wr_waitd_wd_ready", wd_ready, 1);
        chk("wr_waitd_csb", csb, 1);
        chk("wr_busy_cmd_ready", {busy, cmd_ready}, 2'b10);
        tick;
        wd_valid = 1'b0;
        chk("wr_setup_bus", {csb, web, oeb, ce}, 4'b0010);
        chk("wr_setup_addr", addr, 16'h0010);
        chk("wr_setup_idata", idata, 8'hA5);
        tick;
        chk("wr_strobe_bus", {csb, web, oeb, ce}, 4'b0011);
        chk("wr_strobe_idata", idata, 8'hA5);
        tick;
        cmd_valid = 1'b0;
        chk("wr_recov_bus", {csb, web, oeb, ce}, 4'b1110);
        chk("wr_recov_idata", idata, 8'h00);
        chk("wr_recov_cmd_ready", cmd_ready, 0);
        tick;
        chk("wr_done_cmd_ready", cmd_ready, 1);
        chk("wr_done_busy", busy, 0);
        chk("wr_done_csb", csb, 1);

        // Single read from 0x0010; model returns 0xA5.
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0010;
        tick;
        cmd_valid = 1'b0;
        chk("rd_setup_bus", {csb, web, oeb, ce}, 4'b0100);
        chk("rd_setup_idata", idata, 8'h00);
        chk("rd_setup_rdv", rd_valid, 0);
        tick;
        chk("rd_strobe_bus", {csb, web, oeb, ce}, 4'b0101);
        chk("rd_strobe_rdv", rd_valid, 0);
        tick;
        chk("rd_recov_rdv", rd_valid, 1);
        chk("rd_recov_data", rd_data, 8'hA5);
        chk("rd_recov_bus", {csb, web, oeb, ce}, 4'b1110);
        tick;
        chk("rd_done_rdv", rd_valid, 0);
        chk("rd_done_hold", rd_data, 8'hA5);
        chk("rd_done_cmd_ready", cmd_ready, 1);

        // Write with data withheld: bus stays idle in WAITD until the handshake.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0040;
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("stall_csb", csb, 1);
            chk("stall_wd_ready", wd_ready, 1);
            tick;
        end
        wd_valid = 1'b1; wd_data = 8'h3C;
        tick;
        wd_valid = 1'b0;
        chk("stall_setup_bus", {csb, web, oeb, ce}, 4'b0010);
        chk("stall_setup_idata", idata, 8'h3C);
        chk("stall_setup_addr", addr, 16'h0040);
        tick; tick; tick;
        chk("stall_done_busy", busy, 0);

`ifdef MEMIF_BURST_EN
        // Burst read of three beats across the 16-bit address wrap.
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'hFFFE; cmd_len = 8'd2;
        tick;
        cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            logic [15:0] ea;
            ea = 16'hFFFE + 16'(b);
            chk("brd_addr", addr, ea);
            chk("brd_setup_csb", {csb, ce}, 2'b00);
            chk("brd_setup_rdv", rd_valid, 0);
            tick;
            chk("brd_strobe_ce", ce, 1);
            tick;
            chk("brd_rdv", rd_valid, 1);
            chk("brd_data", rd_data, ea[7:0] ^ 8'hB5);
            chk("brd_busy", busy, 1);
            tick;
        end
        chk("brd_done_busy", busy, 0);
        chk("brd_done_rdv", rd_valid, 0);

        // Two-beat write burst; second beat's data withheld for six cycles.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0020; cmd_len = 8'd1;
        wd_valid = 1'b1; wd_data = 8'h11;
        tick;
        cmd_valid = 1'b0;
        tick;
        wd_valid = 1'b0;
        chk("bwr0_setup", {csb, web, idata}, 10'h011);
        chk("bwr0_addr", addr, 16'h0020);
        tick; tick; tick;
        for (int i = 0; i < 6; i++) begin
            chk("bwr_stall_csb", csb, 1);
            chk("bwr_stall_busy", {busy, wd_ready}, 2'b11);
            tick;
        end
        wd_valid = 1'b1; wd_data = 8'h22;
        tick;
        wd_valid = 1'b0;
        chk("bwr1_setup", {csb, web, idata}, 10'h022);
        chk("bwr1_addr", addr, 16'h0021);
        tick;
        chk("bwr1_strobe_ce", ce, 1);
        tick; tick;
        chk("bwr_done_busy", busy, 0);
        cmd_len = 8'd0;
`else
        // CMD_LEN must be ignored: a single beat only.
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'hFFFE; cmd_len = 8'd2;
        tick;
        cmd_valid = 1'b0;
        chk("nolen_addr", addr, 16'hFFFE);
        tick; tick;
        chk("nolen_rdv", {rd_valid, rd_data}, {1'b1, 8'h4B});
        tick;
        chk("nolen_done_busy", busy, 0);
        chk("nolen_csb", csb, 1);
        cmd_len = 8'd0;
`endif

        // Reset during STROBE of a read discards the access.
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0010;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("rst_mid_strobe_ce", ce, 1);
        rst = 1'b1;
        tick;
        chk("rst_mid_bus", {csb, web, oeb, ce}, 4'b1110);
        chk("rst_mid_rdv", rd_valid, 0);
        chk("rst_mid_rd_data", rd_data, 8'h00);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        tick;
        chk("rst_mid_rdv2", rd_valid, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);

        // Stretched timing 2/3/2: CE high for 3 cycles after 2 of setup, 7-cycle beat.
        cmd_valid2 = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0030;
        tick;
        cmd_valid2 = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            chk("t2_ce", ce2, (i >= 3 && i <= 5) ? 1 : 0);
            chk("t2_csb", csb2, (i >= 6) ? 1 : 0);
            chk("t2_rdv", rd_valid2, (i == 6) ? 1 : 0);
            if (i == 6) chk("t2_rd_data", rd_data2, 8'h85);
            tick;
        end
        chk("t2_done_cmd_ready", cmd_ready2, 1);
        chk("t2_done_busy", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
